// File: rtl/sel_a2f.sv
// sel_a2f: return-path selector merging RX IQ samples and ECPU response words
// into a single FTDI TX word stream. ECPU words take priority over samples.
// Optional build macro: SEL_A2F_SIGN_EXT_EN (sign-extend packed I/Q fields).
module sel_a2f #(
    parameter int unsigned FT_DATA_WIDTH    = 32,
    parameter int unsigned IQ_PAIR_WIDTH    = 24,
    parameter int unsigned QSTART_BIT_INDEX = 16,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stream_en_i,
    input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_re_o,
    input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
    input  logic                     cpu_valid_i,
    output logic                     cpu_ready_o,
    output logic [FT_DATA_WIDTH-1:0] data_o,
    output logic                     we_o,
    input  logic                     full_i,
    output logic                     busy_o,
    output logic [CNT_WIDTH-1:0]     tx_count_o
);

    localparam int unsigned HALF = IQ_PAIR_WIDTH / 2;
    localparam int unsigned QTOP = QSTART_BIT_INDEX + HALF;

`ifdef SEL_A2F_SIGN_EXT_EN
    // Bits between the I field and the Q field, and bits above the Q field.
    localparam logic [FT_DATA_WIDTH-1:0] I_EXT_MASK =
        FT_DATA_WIDTH'((64'd1 << QSTART_BIT_INDEX) - (64'd1 << HALF));
    localparam logic [FT_DATA_WIDTH-1:0] Q_EXT_MASK =
        FT_DATA_WIDTH'(~((64'd1 << QTOP) - 64'd1));
`endif

    typedef enum logic {
        ST_IDLE,
        ST_RD
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [FT_DATA_WIDTH-1:0] r_data;
    logic                     r_we;
    logic [CNT_WIDTH-1:0]     r_count;

    logic                     w_slot_free;
    logic                     w_xfer;
    logic                     w_cpu_ready;
    logic                     w_fifo_re;
    logic [HALF-1:0]          w_q;
    logic [HALF-1:0]          w_i;
    logic [FT_DATA_WIDTH-1:0] w_packed;

    assign w_xfer      = r_we & ~full_i;
    assign w_slot_free = ~r_we | ~full_i;
    assign w_q         = fifo_data_i[IQ_PAIR_WIDTH-1:HALF];
    assign w_i         = fifo_data_i[HALF-1:0];

    // Pack one IQ pair into an FTDI word (Q at QSTART_BIT_INDEX, I at bit 0).
    always_comb begin
        w_packed                        = '0;
        w_packed[QTOP-1:QSTART_BIT_INDEX] = w_q;
        w_packed[HALF-1:0]              = w_i;
`ifdef SEL_A2F_SIGN_EXT_EN
        w_packed = w_packed
                 | ({FT_DATA_WIDTH{w_i[HALF-1]}} & I_EXT_MASK)
                 | ({FT_DATA_WIDTH{w_q[HALF-1]}} & Q_EXT_MASK);
`endif
    end

    // Next-state and handshake decode: ECPU word first, then a sample read.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_ready = 1'b0;
        w_fifo_re   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_valid_i && w_slot_free) begin
                    w_cpu_ready = 1'b1;
                end else if (stream_en_i && !fifo_empty_i && w_slot_free) begin
                    w_fifo_re   = 1'b1;
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX word register: load ECPU word or packed sample, drop we_o once taken.
    // The RD load needs no slot test: the read was only issued with the slot
    // free, and the branch below cleared we_o if that word transferred.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_we   <= 1'b0;
        end else if (w_cpu_ready) begin
            r_data <= cpu_data_i;
            r_we   <= 1'b1;
        end else if (r_state == ST_RD) begin
            r_data <= w_packed;
            r_we   <= 1'b1;
        end else if (w_xfer) begin
            r_we   <= 1'b0;
        end
    end

    // Count words accepted by the FTDI; wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Combinational strobes are forced low while reset is held.
    assign cpu_ready_o = w_cpu_ready & ~rst_i;
    assign fifo_re_o   = w_fifo_re & ~rst_i;
    assign data_o      = r_data;
    assign we_o        = r_we;
    assign busy_o      = (r_state != ST_IDLE) | r_we;
    assign tx_count_o  = r_count;

endmodule
